rf_mp_sb: RTL

//  Parametrised multi-port MIPS general register file with an integrated scoreboard, for the dual-issue pipeline.

---
 rtl/rf_mp_sb.sv | 101 ++++++++++
 1 files changed

// File: rtl/rf_mp_sb.sv
// Multi-port general register file with an integrated issue scoreboard.
// NRD combinational read ports, NWR write-back ports, optional write-to-read
// bypass, and one pending bit per register (set on issue, cleared on write-back or flush).
module rf_mp_sb #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NRD    = 4,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DW-1:0]     rd_data,
  output logic [NRD-1:0]        rd_rdy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DW-1:0]     wr_data,
  input  logic [NWR-1:0]        alloc_en,
  input  logic [NWR*AW-1:0]     alloc_addr,
  input  logic                  flush,
  input  logic [AW-1:0]         dbg_addr,
  output logic [DW-1:0]         dbg_data,
  output logic [(1<<AW)-1:0]    pend_vec
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0]    mem_q [Depth];
  logic [DW-1:0]    mem_d [Depth];
  logic [Depth-1:0] pend_q;
  logic [Depth-1:0] pend_d;

  // Next state: ascending port order so the highest enabled port wins a conflict;
  // alloc is applied after write-back so a new producer keeps the register pending,
  // and flush is applied last so it overrides both.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        mem_d[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
        pend_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    for (int j = 0; j < NWR; j++) begin
      if (alloc_en[j]) begin
        pend_d[alloc_addr[j*AW +: AW]] = 1'b1;
      end
    end
    if (flush) begin
      pend_d = '0;
    end
    // Entry 0 is hardwired to zero and never pending.
    mem_d[0]  = '0;
    pend_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < Depth; r++) begin
        mem_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  // Read ports: stored value, optionally overridden by the winning same-cycle write.
  // Forwarding is suppressed during reset since those writes are discarded.
  always_comb begin
    rd_data = '0;
    rd_rdy  = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*DW +: DW] = mem_q[rd_addr[i*AW +: AW]];
      rd_rdy[i]           = ~pend_q[rd_addr[i*AW +: AW]];
      if ((BYPASS != 0) && !rst && (rd_addr[i*AW +: AW] != '0)) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
            rd_data[i*DW +: DW] = wr_data[j*DW +: DW];
            rd_rdy[i]           = 1'b1;
          end
        end
      end
      if (rd_addr[i*AW +: AW] == '0) begin
        rd_data[i*DW +: DW] = '0;
        rd_rdy[i]           = 1'b1;
      end
    end
  end

  // Debug tap and scoreboard view always show stored state.
  always_comb begin
    dbg_data = mem_q[dbg_addr];
    pend_vec = pend_q;
  end

endmodule
